burst_ram_master: RTL
=====================

// Module: burst_ram_master
// PURPOSE
//  Initiator side of the burst RAM command protocol. Turns one-cycle line requests from a cache or client into burst commands.
//  Writes serialise a BURST_COUNT-beat line onto wr_data; reads deserialise BURST_COUNT rd_data beats into one line.
//  Sits between the cache and the burst RAM (IP core in hardware, BurstRAM emulator in simulation).
// PARAMETERS
//  DEPTH_BITWIDTH  4   RAM word-address width (word = DATA_BITWIDTH bits)
//  DATA_BITWIDTH   64  beat width, multiple of 8
//  BURST_COUNT     4   beats per burst, power of 2, >=2
//  (local) LINE_ADDR_BITWIDTH = DEPTH_BITWIDTH - $clog2(BURST_COUNT); LINE_BITWIDTH = BURST_COUNT*DATA_BITWIDTH
// PORTS
//  clk            in   1                  clock
//  rst            in   1                  synchronous, active-high reset
//  req_valid      in   1                  client request present
//  req_ready      out  1                  accept; transfer when req_valid&req_ready at posedge
//  req_write      in   1                  0: read line, 1: write line
//  req_line_addr  in   LINE_ADDR_BITWIDTH line address
//  req_wr_line    in   LINE_BITWIDTH      write line, beat i = [i*DATA_BITWIDTH +: DATA_BITWIDTH]
//  resp_valid     out  1                  one-cycle completion pulse (read data or write ack)
//  resp_rd_line   out  LINE_BITWIDTH      read line, valid with resp_valid, held until next read completes
//  ready_calib    out  1                  registered copy of br_init_calib
//  protocol_err   out  1                  sticky: rd_data_valid outside a read collect
//  br_cmd         out  1                  0: read, 1: write
//  br_cmd_en      out  1                  one-cycle command strobe
//  br_addr        out  DEPTH_BITWIDTH     word address = {line_addr, $clog2(BURST_COUNT)'b0}
//  br_wr_data     out  DATA_BITWIDTH      write beat
//  br_data_mask   out  DATA_BITWIDTH/8    constant 0 (all bytes written)
//  br_rd_data     in   DATA_BITWIDTH      read beat
//  br_rd_data_valid in 1                  read beat valid
//  br_init_calib  in   1                  RAM calibrated
//  br_busy        in   1                  RAM busy (registered in RAM, lags cmd_en by one cycle)
// BEHAVIOUR
//  Reset: all outputs 0, resp_rd_line 0, protocol_err 0, state WAIT_CALIB. Reset mid-burst abandons it; the RAM shares rst.
//  States:
//   WAIT_CALIB    -> IDLE when br_init_calib=1.
//   IDLE          req_ready = !br_busy. On accept, latch the request and go to ISSUE.
//   ISSUE         br_cmd_en=1, br_cmd=req_write, br_addr set.
//                 Write: br_wr_data=beat0, beat_cnt=1, -> WRITE_BEATS.
//                 Read: beat_cnt=0, -> READ_COLLECT.
//   WRITE_BEATS   br_wr_data=beat[beat_cnt] on consecutive cycles. After beat BURST_COUNT-1 -> WAIT_DONE.
//   WAIT_DONE     when br_busy=0: resp_valid=1 for one cycle, -> IDLE.
//   READ_COLLECT  each cycle with br_rd_data_valid stores beat[beat_cnt] and increments.
//                 Last beat: resp_valid=1 next cycle with the full line, -> IDLE.
//  Timing:
//   - br_cmd_en, br_cmd, br_addr and br_wr_data are registered; req_ready is combinational from state and br_busy.
//   - Accept at edge N gives cmd_en high in cycle N+1. Write beats occupy cycles N+1..N+BURST_COUNT, no gaps.
//   - Read latency is RAM-defined; beats must arrive contiguous. A gap stalls collection (no timeout).
//   - Because br_busy lags, IDLE never re-accepts in the cycle directly after ISSUE. Back-to-back requests are spaced by the RAM's busy release.
//  Boundaries:
//   - beat_cnt is $clog2(BURST_COUNT) bits and wraps at BURST_COUNT.
//   - Highest line_addr maps to the top BURST_COUNT words, no address wrap.
//   - req_valid while not ready: held off, no state change.
//   - br_rd_data_valid in any state other than READ_COLLECT sets protocol_err; the beat is discarded.
//   - br_init_calib dropping after calibration is ignored (ready_calib follows it).
// STRUCTURE
//  Shared package burst_ram_pkg: CMD_READ=0/CMD_WRITE=1, one-hot state encodings, width helper localparams.
//  One natural sub-module: burst_line_shifter (line<->beat serialiser/deserialiser with beat counter).
// TESTING (bench pairs this block with BurstRAM, init 10, read delay 8, BURST_COUNT 4)
//  1. rst for 2 cycles then release -> req_ready=0 until br_init_calib. No br_cmd_en during calibration.
//  2. Write line 2 = {64'h4,64'h3,64'h2,64'h1} -> cmd_en one cycle, addr=8.
//     Beats 1,2,3,4 on 4 consecutive cycles; RAM words 8..11 = 1..4; resp_valid once.
//  3. Read line 2 after test 2 -> resp_rd_line={4,3,2,1}, resp_valid exactly once, protocol_err stays 0.
//  4. Write line 3 with req_valid held, then read line 0 -> second accept only after br_busy low.
//     Read returns the file/zero contents, no overlap of cmd_en.
//  5. Force br_rd_data_valid=1 for one cycle in IDLE -> protocol_err=1 and stays set until rst.
//  6. Assert rst during READ_COLLECT -> next cycle all outputs 0, state WAIT_CALIB; a fresh read then completes correctly.

Source files
------------

// File: rtl/burst_ram_pkg.sv
// Shared definitions for the burst RAM initiator: command codes,
// one-hot FSM state encodings and a width helper.
package burst_ram_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int ST_W = 6;

  localparam int I_WAIT_CALIB   = 0;
  localparam int I_IDLE         = 1;
  localparam int I_ISSUE        = 2;
  localparam int I_WRITE_BEATS  = 3;
  localparam int I_WAIT_DONE    = 4;
  localparam int I_READ_COLLECT = 5;

  localparam logic [ST_W-1:0] S_WAIT_CALIB   = 6'b000001;
  localparam logic [ST_W-1:0] S_IDLE         = 6'b000010;
  localparam logic [ST_W-1:0] S_ISSUE        = 6'b000100;
  localparam logic [ST_W-1:0] S_WRITE_BEATS  = 6'b001000;
  localparam logic [ST_W-1:0] S_WAIT_DONE    = 6'b010000;
  localparam logic [ST_W-1:0] S_READ_COLLECT = 6'b100000;

  function automatic int line_addr_bw(
    input int depth_bw,
    input int burst
  );
    return depth_bw - $clog2(burst);
  endfunction

endpackage

// File: rtl/burst_ram_master_if.sv
// Client request/response and burst RAM command signals.
// master: the initiator; slave: client plus RAM side.
interface burst_ram_master_if
  import burst_ram_pkg::*;
#(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int DATA_BITWIDTH  = 64,
  parameter int BURST_COUNT    = 4
);
  localparam int LAW = line_addr_bw(DEPTH_BITWIDTH, BURST_COUNT);
  localparam int LW  = BURST_COUNT * DATA_BITWIDTH;
  localparam int MW  = DATA_BITWIDTH / 8;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [LAW-1:0]            req_line_addr;
  logic [LW-1:0]             req_wr_line;
  logic                      resp_valid;
  logic [LW-1:0]             resp_rd_line;
  logic                      ready_calib;
  logic                      protocol_err;
  logic                      br_cmd;
  logic                      br_cmd_en;
  logic [DEPTH_BITWIDTH-1:0] br_addr;
  logic [DATA_BITWIDTH-1:0]  br_wr_data;
  logic [MW-1:0]             br_data_mask;
  logic [DATA_BITWIDTH-1:0]  br_rd_data;
  logic                      br_rd_data_valid;
  logic                      br_init_calib;
  logic                      br_busy;

  modport master (
    input  req_valid, req_write,
    input  req_line_addr, req_wr_line,
    output req_ready, resp_valid,
    output resp_rd_line,
    output ready_calib, protocol_err,
    output br_cmd, br_cmd_en, br_addr,
    output br_wr_data, br_data_mask,
    input  br_rd_data, br_rd_data_valid,
    input  br_init_calib, br_busy
  );

  modport slave (
    output req_valid, req_write,
    output req_line_addr, req_wr_line,
    input  req_ready, resp_valid,
    input  resp_rd_line,
    input  ready_calib, protocol_err,
    input  br_cmd, br_cmd_en, br_addr,
    input  br_wr_data, br_data_mask,
    output br_rd_data, br_rd_data_valid,
    output br_init_calib, br_busy
  );

endinterface

// File: rtl/burst_line_shifter.sv
// Line<->beat serialiser/deserialiser with wrapping beat counter.
// load: latch line+count; step: advance; capture: store beat_in.
module burst_line_shifter #(
  parameter int DATA_BITWIDTH = 64,
  parameter int BURST_COUNT   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [BURST_COUNT*DATA_BITWIDTH-1:0] load_line,
  input  logic [$clog2(BURST_COUNT)-1:0]       load_cnt,
  input  logic step,
  input  logic capture,
  input  logic [DATA_BITWIDTH-1:0]             beat_in,
  output logic [$clog2(BURST_COUNT)-1:0]       cnt,
  output logic [DATA_BITWIDTH-1:0]             beat,
  output logic [BURST_COUNT*DATA_BITWIDTH-1:0] line_next
);
  localparam int CW = $clog2(BURST_COUNT);
  localparam int LW = BURST_COUNT * DATA_BITWIDTH;

  logic [LW-1:0] line_q;
  logic [CW-1:0] cnt_q;

  assign cnt  = cnt_q;
  assign beat = line_q[int'(cnt_q)*DATA_BITWIDTH +: DATA_BITWIDTH];

  // Line as it will look once the incoming beat lands in its slot,
  // so the final beat can complete the response without a bubble.
  always_comb begin
    line_next = line_q;
    line_next[int'(cnt_q)*DATA_BITWIDTH +: DATA_BITWIDTH] = beat_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      line_q <= load_line;
      cnt_q  <= load_cnt;
    end else if (capture) begin
      line_q <= line_next;
      cnt_q  <= cnt_q + 1'b1;
    end else if (step) begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/burst_ram_master.sv
// Burst RAM initiator: one-cycle line requests to burst commands.
// Ports: clk, rst (sync, active-high), bus (burst_ram_master_if.master).
module burst_ram_master
  import burst_ram_pkg::*;
#(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int DATA_BITWIDTH  = 64,
  parameter int BURST_COUNT    = 4
) (
  input logic clk,
  input logic rst,
  burst_ram_master_if.master bus
);
  localparam int CW = $clog2(BURST_COUNT);
  localparam int LW = BURST_COUNT * DATA_BITWIDTH;

  logic [ST_W-1:0]           state;
  logic                      cmd_en_q;
  logic                      cmd_q;
  logic [DEPTH_BITWIDTH-1:0] addr_q;
  logic [DATA_BITWIDTH-1:0]  wr_data_q;
  logic                      resp_valid_q;
  logic [LW-1:0]             resp_line_q;
  logic                      calib_q;
  logic                      perr_q;

  logic                      accept;
  logic                      step;
  logic                      capture;
  logic                      last_beat;
  logic [CW-1:0]             cnt;
  logic [DATA_BITWIDTH-1:0]  beat;
  logic [LW-1:0]             line_next;

  assign bus.req_ready    = state[I_IDLE] && !bus.br_busy;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rd_line = resp_line_q;
  assign bus.ready_calib  = calib_q;
  assign bus.protocol_err = perr_q;
  assign bus.br_cmd       = cmd_q;
  assign bus.br_cmd_en    = cmd_en_q;
  assign bus.br_addr      = addr_q;
  assign bus.br_wr_data   = wr_data_q;
  assign bus.br_data_mask = '0;

  assign accept = state[I_IDLE]
                && bus.req_valid
                && !bus.br_busy;

  // Beat 0 leaves with the command, so the counter
  // already points at beat 1 in ISSUE for a write.
  assign step = (state[I_ISSUE] && cmd_q == CMD_WRITE)
              || (state[I_WRITE_BEATS] && cnt != '0);

  assign capture = state[I_READ_COLLECT]
                 && bus.br_rd_data_valid;

  assign last_beat = cnt == CW'(BURST_COUNT - 1);

  burst_line_shifter #(
    .DATA_BITWIDTH (DATA_BITWIDTH),
    .BURST_COUNT   (BURST_COUNT)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_line (bus.req_wr_line),
    .load_cnt  (CW'(bus.req_write)),
    .step      (step),
    .capture   (capture),
    .beat_in   (bus.br_rd_data),
    .cnt       (cnt),
    .beat      (beat),
    .line_next (line_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_WAIT_CALIB;
      cmd_en_q     <= 1'b0;
      cmd_q        <= CMD_READ;
      addr_q       <= '0;
      wr_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_line_q  <= '0;
      calib_q      <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      calib_q      <= bus.br_init_calib;
      cmd_en_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      if (bus.br_rd_data_valid
          && !state[I_READ_COLLECT])
        perr_q <= 1'b1;
      unique case (1'b1)
        state[I_WAIT_CALIB]: begin
          if (bus.br_init_calib)
            state <= S_IDLE;
        end
        state[I_IDLE]: begin
          if (accept) begin
            cmd_en_q <= 1'b1;
            cmd_q    <= bus.req_write;
            addr_q   <= {bus.req_line_addr,
                         {CW{1'b0}}};
            wr_data_q <= bus.req_write
              ? bus.req_wr_line[DATA_BITWIDTH-1:0]
              : '0;
            state <= S_ISSUE;
          end
        end
        state[I_ISSUE]: begin
          if (cmd_q == CMD_WRITE) begin
            wr_data_q <= beat;
            state     <= S_WRITE_BEATS;
          end else begin
            state <= S_READ_COLLECT;
          end
        end
        state[I_WRITE_BEATS]: begin
          if (cnt == '0) begin
            wr_data_q <= '0;
            state     <= S_WAIT_DONE;
          end else begin
            wr_data_q <= beat;
          end
        end
        state[I_WAIT_DONE]: begin
          if (!bus.br_busy) begin
            resp_valid_q <= 1'b1;
            state        <= S_IDLE;
          end
        end
        state[I_READ_COLLECT]: begin
          if (capture && last_beat) begin
            resp_valid_q <= 1'b1;
            resp_line_q  <= line_next;
            state        <= S_IDLE;
          end
        end
        default: state <= S_WAIT_CALIB;
      endcase
    end
  end

endmodule
